regfile_wb_queue: RTL and testbench

- Write-back buffer sitting directly upstream of the 32x32 register file's single write port.
- Accepts register-write results from the execute/multdiv side through a valid/ready handshake and holds them in a small in-order FIFO.
- Drains one write per cycle onto the regfile's ctrl_writeEn / ctrl_writeReg / data_writeReg inputs.
- Exposes a combinational forwarding lookup so readers can see pending, not-yet-written values.

---
 rtl/regfile_wb_queue.sv | 122 ++++++++++++
 tb/tb_regfile_wb_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
// Write-back buffer in front of the 32x32 register file's single write port.
// Register writes enter through a valid/ready handshake, wait in an in-order
// FIFO, and drain one per cycle onto the regfile write port. A combinational
// lookup lets readers see pending values that have not been written yet.
//
// Ports:
//   clock, ctrl_reset                  clock and synchronous active-high reset
//   in_valid/in_ready/in_reg/in_data   producer handshake and write payload
//   drain_hold                         freezes the head entry when high
//   ctrl_writeEn/ctrl_writeReg/
//   data_writeReg                      regfile write port (head entry)
//   lookup_reg/lookup_hit/lookup_data  forwarding query (youngest match)
//   count                              current occupancy, 0..DEPTH
module regfile_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_reg,
  input  logic [31:0]      in_data,
  input  logic             drain_hold,
  output logic             ctrl_writeEn,
  output logic [4:0]       ctrl_writeReg,
  output logic [31:0]      data_writeReg,
  input  logic [4:0]       lookup_reg,
  output logic             lookup_hit,
  output logic [31:0]      lookup_data,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

  logic [4:0]       entryReg_q  [DEPTH];
  logic [31:0]      entryData_q [DEPTH];
  logic [DEPTH-1:0] entryValid_q;
  logic [PTR_W-1:0] rdPtr_q, wrPtr_q;
  logic [PTR_W:0]   count_q, count_d;

  logic             doStore;
  logic             doPop;
  logic             notEmpty;
  logic [PTR_W-1:0] scanIdx;

  assign notEmpty = (count_q != '0);
  assign in_ready = (count_q < DepthCnt);
  assign count    = count_q;

  // Register 0 completes the handshake but is dropped: it is hardwired zero.
  assign doStore = in_valid & in_ready & (in_reg != 5'd0);
  // Reset gates the write port so pending entries never reach the regfile.
  assign doPop   = notEmpty & ~drain_hold & ~ctrl_reset;

  always_comb begin
    count_d = count_q;
    unique case ({doStore, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ctrl_writeEn  = doPop;
    ctrl_writeReg = 5'd0;
    data_writeReg = 32'd0;
    if (notEmpty && !ctrl_reset) begin
      ctrl_writeReg = entryReg_q[rdPtr_q];
      data_writeReg = entryData_q[rdPtr_q];
    end
  end

  // Walk from oldest to youngest so the last match seen is the youngest one.
  // Only pending entries carry a valid bit, so the head being issued still hits.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = 32'd0;
    scanIdx     = rdPtr_q;
    if (lookup_reg != 5'd0 && !ctrl_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        scanIdx = rdPtr_q + PTR_W'(i);
        if (entryValid_q[scanIdx] && entryReg_q[scanIdx] == lookup_reg) begin
          lookup_hit  = 1'b1;
          lookup_data = entryData_q[scanIdx];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      count_q      <= '0;
      entryValid_q <= '0;
    end else begin
      // Pop and store never hit the same slot: store needs not-full and pop
      // needs not-empty, so rdPtr_q != wrPtr_q whenever both fire.
      if (doPop) begin
        entryValid_q[rdPtr_q] <= 1'b0;
        rdPtr_q               <= rdPtr_q + 1'b1;
      end
      if (doStore) begin
        entryValid_q[wrPtr_q] <= 1'b1;
        wrPtr_q               <= wrPtr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge clock) begin
    if (doStore && !ctrl_reset) begin
      entryReg_q[wrPtr_q]  <= in_reg;
      entryData_q[wrPtr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: directed scenarios plus randomized traffic.
// Accepted writes go into an expected-write queue; a negedge monitor compares
// the write port, occupancy, ready and forwarding lookup against that queue,
// and a behavioural regfile model is compared against a regfile written by
// the DUT at the end.
module tb_regfile_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic              clock = 1'b0;
  logic              ctrl_reset;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_reg;
  logic [31:0]       in_data;
  logic              drain_hold;
  logic              ctrl_writeEn;
  logic [4:0]        ctrl_writeReg;
  logic [31:0]       data_writeReg;
  logic [4:0]        lookup_reg;
  logic              lookup_hit;
  logic [31:0]       lookup_data;
  logic [PTR_W:0]    count;

  regfile_wb_queue #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg        (in_reg),
    .in_data       (in_data),
    .drain_hold    (drain_hold),
    .ctrl_writeEn  (ctrl_writeEn),
    .ctrl_writeReg (ctrl_writeReg),
    .data_writeReg (data_writeReg),
    .lookup_reg    (lookup_reg),
    .lookup_hit    (lookup_hit),
    .lookup_data   (lookup_data),
    .count         (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        expQ[$];
  logic [31:0] rfEnv [32];
  logic [31:0] rfRef [32];
  bit          inReadyExp = 1'b1;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Regfile environment: captures whatever the DUT writes.
  always @(posedge clock) begin
    if (ctrl_writeEn && ctrl_writeReg != 5'd0) rfEnv[ctrl_writeReg] <= data_writeReg;
  end

  // Stimulus-side recorder: an offered write is accepted if the queue had room.
  always @(posedge clock) begin
    if (ctrl_reset) begin
      expQ.delete();
    end else if (in_valid && inReadyExp && in_reg != 5'd0) begin
      expQ.push_back('{r: in_reg, d: in_data});
    end
  end

  // Monitor: inputs are stable between #1 after posedge and the next posedge.
  always @(negedge clock) begin
    int    sz;
    bit    expHit;
    logic [31:0] expData;
    bit    expWen;
    sz = expQ.size();
    chk("count", 32'(count), 32'(sz));
    chk("count_bound", 32'(count <= DEPTH), 32'd1);
    chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
    inReadyExp = (sz < DEPTH);

    expHit  = 1'b0;
    expData = 32'd0;
    if (!ctrl_reset && lookup_reg != 5'd0) begin
      for (int i = sz - 1; i >= 0; i--) begin
        if (expQ[i].r == lookup_reg) begin
          expHit  = 1'b1;
          expData = expQ[i].d;
          break;
        end
      end
    end
    chk("lookup_hit", 32'(lookup_hit), 32'(expHit));
    chk("lookup_data", lookup_data, expData);

    expWen = !ctrl_reset && sz != 0 && !drain_hold;
    chk("writeEn", 32'(ctrl_writeEn), 32'(expWen));
    if (ctrl_reset || sz == 0) begin
      chk("idle_writeReg", 32'(ctrl_writeReg), 32'd0);
      chk("idle_writeData", data_writeReg, 32'd0);
    end else begin
      chk("head_writeReg", 32'(ctrl_writeReg), 32'(expQ[0].r));
      chk("head_writeData", data_writeReg, expQ[0].d);
    end
    if (expWen) begin
      rfRef[expQ[0].r] = expQ[0].d;
      void'(expQ.pop_front());
    end
  end

  task automatic cyc(input bit v, input logic [4:0] r, input logic [31:0] d,
                     input bit h, input bit rst, input int lk);
    in_valid   = v;
    in_reg     = r;
    in_data    = d;
    drain_hold = h;
    ctrl_reset = rst;
    lookup_reg = (lk < 0) ? 5'($urandom_range(0, 31)) : 5'(lk);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, h, 1'b0, -1);
  endtask

  initial begin
    int  cycn;
    bit  ok;
    bit  done;
    int  guard;
    for (int i = 0; i < 32; i++) begin
      rfEnv[i] = 32'd0;
      rfRef[i] = 32'd0;
    end
    in_valid = 1'b0; in_reg = 5'd0; in_data = 32'd0;
    drain_hold = 1'b0; ctrl_reset = 1'b1; lookup_reg = 5'd0;
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 0);

    // Reset discards pending entries.
    cyc(1'b1, 5'd3, 32'h11, 1'b1, 1'b0, 3);
    cyc(1'b1, 5'd4, 32'h22, 1'b1, 1'b0, 4);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 3);
    idle(3, 1'b0);

    // Basic drain.
    cyc(1'b1, 5'd1, 32'h0000DEAD, 1'b0, 1'b0, 1);
    cyc(1'b1, 5'd2, 32'hAAAADEAD, 1'b0, 1'b0, 1);
    idle(3, 1'b0);

    // Full / backpressure: r9 is refused.
    for (int i = 5; i <= 9; i++) cyc(1'b1, 5'(i), 32'(i * 16'h101), 1'b1, 1'b0, -1);
    idle(6, 1'b0);

    // Register 0 is accepted but never written.
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    idle(2, 1'b0);

    // Forwarding picks the youngest match.
    cyc(1'b1, 5'd7, 32'h1, 1'b1, 1'b0, 7);
    cyc(1'b1, 5'd8, 32'h2, 1'b1, 1'b0, 7);
    cyc(1'b1, 5'd7, 32'h3, 1'b1, 1'b0, 7);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 7);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 9);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 7);
    idle(5, 1'b0);

    // Wrap-around with simultaneous push/pop, hold toggled every 3 cycles.
    cycn = 0;
    for (int i = 1; i < 32; i++) begin
      done  = 1'b0;
      guard = 0;
      while (!done) begin
        ok = in_ready;
        cyc(1'b1, 5'(i), 32'(i), ((cycn / 3) % 2) == 1, 1'b0, -1);
        cycn++;
        guard++;
        done = ok;
        if (!done && guard > 50) begin
          checks++;
          errors++;
          $display("FAIL wrap_push_timeout: got stalled expected accept for r%0d", i);
          done = 1'b1;
        end
      end
    end
    idle(8, 1'b0);

    // Randomized traffic, occasional reset.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0), -1);
    end
    idle(8, 1'b0);

    for (int i = 0; i < 32; i++) chk($sformatf("regfile_r%0d", i), rfEnv[i], rfRef[i]);
    chk("final_empty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
